// File: rtl/fuzz_stim_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fuzz_pkg
// Description : Shared constants, state encoding and helpers for the fuzz
//               stimulus scheduler (LCG coefficients, MISR taps, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package fuzz_pkg;

  localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;

  localparam int MISR_TAP_31 = 31;
  localparam int MISR_TAP_21 = 21;
  localparam int MISR_TAP_1  = 1;
  localparam int MISR_TAP_0  = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    LOAD  = 3'd2,
    STEP  = 3'd3,
    GEN   = 3'd4,
    APPLY = 3'd5,
    DONE  = 3'd6
  } state_t;

  function automatic int nchunk(input int w);
    return (w + 31) / 32;
  endfunction

  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    return s * LCG_MUL + LCG_INC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fuzz_stim_scheduler_lcg32.sv
`default_nettype none
// ============================================================================
// Module      : fuzz_lcg32
// Description : Registered 32-bit LCG. val always holds the next chunk to be
//               consumed, so a load presents the first successor of the seed.
// Revision    : 1.0 - initial release
// ============================================================================
module fuzz_lcg32
  import fuzz_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] val
);

  logic [31:0] r_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= 32'h0;
    end else if (load) begin
      r_val <= lcg_next(seed);
    end else if (adv) begin
      r_val <= lcg_next(r_val);
    end
  end

  assign val = r_val;

endmodule
`default_nettype wire

// File: rtl/fuzz_stim_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fuzz_stim_scheduler
// Description : Stimulus sequencer for a clock-enabled fuzz DUT: holds its
//               reset, applies LCG-built vectors, steps it, and folds its
//               outputs into a 32-bit MISR signature.
// Revision    : 1.0 - initial release
// ============================================================================
module fuzz_stim_scheduler
  import fuzz_pkg::*;
#(
  parameter int IN_W       = 258,
  parameter int OUT_W      = 330,
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] cycles,
  output logic             dut_rst_n,
  output logic [IN_W-1:0]  dut_in,
  output logic             dut_step,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_count,
  output logic [31:0]      signature
);

  localparam int NCHUNK  = nchunk(IN_W);
  localparam int SH_W    = NCHUNK * 32;
  localparam int RST_LEN = (RST_CYCLES > NCHUNK) ? RST_CYCLES : NCHUNK;
  localparam int CW      = $clog2(RST_LEN + 1);
  localparam int NSLICE  = nchunk(OUT_W);
  localparam int FOLD_W  = NSLICE * 32;

  state_t           r_state;
  logic [CW-1:0]    r_chunk;
  logic [SH_W-1:0]  r_shadow;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_cyc_count;
  logic [31:0]      r_sig;
  logic [IN_W-1:0]  r_dut_in;
  logic             r_dut_rst_n;
  logic             r_step;
  logic             r_busy;
  logic             r_done;

  logic             w_start_ok;
  logic             w_adv;
  logic [31:0]      w_lcg_val;
  logic [SH_W-1:0]  w_shadow_nxt;
  logic [FOLD_W-1:0] w_out_pad;
  logic [31:0]      w_fold;
  logic [31:0]      w_misr_nxt;

  // A new run may begin from IDLE or DONE; abort always takes priority.
  assign w_start_ok = start && !abort && ((r_state == IDLE) || (r_state == DONE));
  assign w_adv      = ((r_state == RST) || (r_state == GEN)) && (r_chunk < CW'(NCHUNK));

  fuzz_lcg32 u_lcg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_start_ok),
    .seed  (seed),
    .adv   (w_adv && !abort),
    .val   (w_lcg_val)
  );

  // Shadow with the chunk being generated this cycle already merged in, so the
  // final generator cycle can hand a complete vector straight to dut_in.
  for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
    assign w_shadow_nxt[32*k +: 32] = (w_adv && (r_chunk == CW'(k))) ? w_lcg_val
                                                                      : r_shadow[32*k +: 32];
  end

  assign w_out_pad = FOLD_W'(dut_out);

  always_comb begin
    w_fold = 32'h0;
    for (int i = 0; i < NSLICE; i++) begin
      w_fold = w_fold ^ w_out_pad[32*i +: 32];
    end
  end

  assign w_misr_nxt = {r_sig[30:0], r_sig[MISR_TAP_31] ^ r_sig[MISR_TAP_21] ^
                                    r_sig[MISR_TAP_1]  ^ r_sig[MISR_TAP_0]} ^ w_fold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_chunk     <= '0;
      r_shadow    <= '0;
      r_cycles    <= '0;
      r_cyc_count <= '0;
      r_sig       <= 32'h0;
      r_dut_in    <= '0;
      r_dut_rst_n <= 1'b0;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_chunk     <= '0;
      r_dut_rst_n <= 1'b0;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state     <= RST;
            r_chunk     <= '0;
            r_cycles    <= cycles;
            r_cyc_count <= '0;
            r_sig       <= 32'h0;
            r_dut_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        RST: begin
          r_shadow <= w_shadow_nxt;
          if (r_chunk == CW'(RST_LEN - 1)) begin
            r_state     <= LOAD;
            r_chunk     <= '0;
            r_dut_in    <= w_shadow_nxt[IN_W-1:0];
            r_dut_rst_n <= 1'b1;
          end else begin
            r_chunk <= r_chunk + 1'b1;
          end
        end
        LOAD: begin
          r_state <= STEP;
          r_step  <= 1'b1;
        end
        STEP: begin
          r_step <= 1'b0;
          r_sig  <= w_misr_nxt;
          if (r_cyc_count == r_cycles) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= GEN;
            r_chunk <= '0;
          end
        end
        GEN: begin
          r_shadow <= w_shadow_nxt;
          if (r_chunk == CW'(NCHUNK - 1)) begin
            r_state  <= APPLY;
            r_chunk  <= '0;
            r_dut_in <= w_shadow_nxt[IN_W-1:0];
          end else begin
            r_chunk <= r_chunk + 1'b1;
          end
        end
        APPLY: begin
          r_state     <= STEP;
          r_step      <= 1'b1;
          r_cyc_count <= r_cyc_count + 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dut_rst_n = r_dut_rst_n;
  assign dut_in    = r_dut_in;
  assign dut_step  = r_step;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cyc_count = r_cyc_count;
  assign signature = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_fuzz_stim_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fuzz_stim_scheduler
// Description : Directed self-checking bench for fuzz_stim_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fuzz_stim_scheduler;

  localparam int IN_W  = 258;
  localparam int OUT_W = 330;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      seed = 32'h0;
  logic [CNT_W-1:0] cycles = '0;
  logic             dut_rst_n;
  logic [IN_W-1:0]  dut_in;
  logic             dut_step;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cyc_count;
  logic [31:0]      signature;
  logic [1:0]       out_mode = 2'd0;

  int n_chk  = 0;
  int n_fail = 0;

  int              m_steps, m_rst_low, m_done_dly, m_min_gap, m_max_gap, m_timeout;
  logic [IN_W-1:0] m_load_vec;
  logic [IN_W-1:0] m_vec [8];

  always #5 clk = ~clk;

  always_comb begin
    case (out_mode)
      2'd0:    dut_out = '0;
      2'd1:    dut_out = OUT_W'(1);
      default: dut_out = {dut_in[71:0], dut_in};
    endcase
  end

  fuzz_stim_scheduler #(
    .IN_W(IN_W), .OUT_W(OUT_W), .RST_CYCLES(2), .CNT_W(CNT_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .cycles    (cycles),
    .dut_rst_n (dut_rst_n),
    .dut_in    (dut_in),
    .dut_step  (dut_step),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .cyc_count (cyc_count),
    .signature (signature)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h3039;
  endfunction

  function automatic logic [IN_W-1:0] mvec(input logic [31:0] sd, input int v);
    logic [287:0] w;
    logic [31:0]  s;
    w = '0;
    s = sd;
    for (int n = 0; n <= v; n++) begin
      for (int k = 0; k < 9; k++) begin
        s = lcg(s);
        w[32*k +: 32] = s;
      end
    end
    return w[IN_W-1:0];
  endfunction

  function automatic logic [31:0] mfold(input logic [IN_W-1:0] vec, input logic [1:0] mode);
    logic [351:0] pad;
    logic [31:0]  f;
    pad = '0;
    if (mode == 2'd1) pad[0] = 1'b1;
    else if (mode == 2'd2) pad[OUT_W-1:0] = {vec[71:0], vec};
    f = 32'h0;
    for (int i = 0; i < 11; i++) f = f ^ pad[32*i +: 32];
    return f;
  endfunction

  function automatic logic [31:0] msig(input logic [31:0] sd, input int ncyc, input logic [1:0] mode);
    logic [31:0] s;
    s = 32'h0;
    for (int v = 0; v <= ncyc; v++) begin
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ mfold(mvec(sd, v), mode);
    end
    return s;
  endfunction

  function automatic logic [63:0] dig(input logic [IN_W-1:0] v);
    logic [319:0] p;
    logic [63:0]  d;
    p = '0;
    p[IN_W-1:0] = v;
    d = '0;
    for (int i = 0; i < 5; i++) d = d ^ p[64*i +: 64];
    return d;
  endfunction

  // Launch a run and watch it at negedges until done, an abort point or the budget.
  task automatic run(input logic [31:0] s, input logic [31:0] c, input int abort_at, input bit poke);
    int  last;
    int  gap;
    int  budget;
    bit  hi;
    m_steps = 0; m_rst_low = 0; m_done_dly = -1; m_min_gap = 1000; m_max_gap = 0;
    m_timeout = 1; hi = 1'b0; last = 0;
    budget = 11 * (int'(c) + 1) + 30;
    @(negedge clk);
    seed = s; cycles = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (!hi && !dut_rst_n) m_rst_low++;
      else if (!hi) begin
        hi = 1'b1;
        m_load_vec = dut_in;
      end
      if (dut_step) begin
        if (m_steps < 8) m_vec[m_steps] = dut_in;
        if (m_steps > 0) begin
          gap = cyc - last;
          if (gap < m_min_gap) m_min_gap = gap;
          if (gap > m_max_gap) m_max_gap = gap;
        end
        last = cyc;
        m_steps++;
        if (poke) begin
          start = 1'b1;
          seed  = 32'h777;
        end
      end
      if (done) begin
        m_done_dly = cyc - last;
        m_timeout  = 0;
        break;
      end
      if (abort_at >= 0 && m_steps == abort_at && cyc == last + 3) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m_timeout = 0;
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    logic [IN_W-1:0] ev;
    int              extra;

    repeat (3) @(negedge clk);
    chk("rst_flags", {busy, done, dut_step, dut_rst_n}, 64'h0);
    chk("rst_dut_in", dut_in[63:0], 64'h0);
    chk("rst_sig", signature, 64'h0);
    chk("rst_cnt", cyc_count, 64'h0);
    rst_n = 1'b1;

    // seed=1, single vector
    out_mode = 2'd0;
    run(32'h1, 32'h0, -1, 1'b0);
    chk("t1_timeout", m_timeout, 0);
    chk("t1_load_chunk0", m_load_vec[31:0], 32'h41C67EA6);
    chk("t1_steps", m_steps, 1);
    chk("t1_done_delay", m_done_dly, 1);
    chk("t1_sig", signature, 0);

    // seed=0, three extra vectors
    run(32'h0, 32'h3, -1, 1'b0);
    ev = mvec(32'h0, 0);
    chk("t2_timeout", m_timeout, 0);
    chk("t2_rst_low", m_rst_low, 9);
    chk("t2_load_chunk0", m_load_vec[31:0], 32'h00003039);
    chk("t2_load_chunk1", m_load_vec[63:32], 32'hD3DC167E);
    chk("t2_load_top", m_load_vec[257:256], ev[257:256]);
    chk("t2_steps", m_steps, 4);
    chk("t2_min_gap", m_min_gap, 11);
    chk("t2_max_gap", m_max_gap, 11);
    chk("t2_cyc_count", cyc_count, 3);
    chk("t2_end_flags", {busy, done, dut_rst_n}, 64'h3);
    chk("t2_sig", signature, 0);

    // dut_out=1, single vector
    out_mode = 2'd1;
    run(32'hCAFE, 32'h0, -1, 1'b0);
    chk("t3_sig", signature, 32'h00000001);

    // abort and start together from DONE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_wins", {busy, done, dut_rst_n}, 64'h0);

    // abort in GEN of vector 2, then rerun same seed
    out_mode = 2'd2;
    run(32'h0, 32'h3, 2, 1'b0);
    chk("t4_abort_flags", {busy, done, dut_step, dut_rst_n}, 64'h0);
    chk("t4_cnt_hold", cyc_count, 1);
    chk("t4_sig_hold", signature, msig(32'h0, 1, 2'd2));
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dut_step) extra++;
    end
    chk("t4_no_step", extra, 0);
    run(32'h0, 32'h3, -1, 1'b0);
    chk("t4_re_steps", m_steps, 4);
    for (int v = 0; v < 4; v++) chk("t4_re_vec", dig(m_vec[v]), dig(mvec(32'h0, v)));
    chk("t4_re_sig", signature, msig(32'h0, 3, 2'd2));

    // start pulsed during STEP is ignored
    run(32'h5, 32'h2, -1, 1'b1);
    chk("t5_steps", m_steps, 3);
    chk("t5_cnt", cyc_count, 2);
    chk("t5_sig", signature, msig(32'h5, 2, 2'd2));

    // rst_n mid-GEN
    @(negedge clk);
    seed = 32'h0; cycles = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !dut_step; i++) @(negedge clk);
    chk("t5_pre_step", dut_step, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_flags", {busy, done, dut_step, dut_rst_n}, 64'h0);
    chk("t5_async_in", dut_in[63:0], 64'h0);
    chk("t5_async_sig", signature, 0);
    chk("t5_async_cnt", cyc_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // two back-to-back identical runs
    for (int r = 0; r < 2; r++) begin
      run(32'h1234, 32'h2, -1, 1'b0);
      chk("t6_timeout", m_timeout, 0);
      for (int v = 0; v < 3; v++) chk("t6_vec", dig(m_vec[v]), dig(mvec(32'h1234, v)));
      chk("t6_sig", signature, msig(32'h1234, 2, 2'd2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
